// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one single-port RAM among num_req requesters
// Each access is IDLE -> ACCESS (-> TURN after a write); every output is a flop.
module ram_port_arbiter #(
   parameter  int data_width = 8,
   parameter  int ram_depth  = 256,
   parameter  int num_req    = 4,
   localparam int addr_width = (ram_depth > 1) ? $clog2(ram_depth) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [num_req-1:0]             req,
   input  logic [num_req-1:0]             we,
   input  logic [num_req*addr_width-1:0]  addr,
   input  logic [num_req*data_width-1:0]  wdata,
   output logic [num_req-1:0]             gnt,
   output logic [num_req-1:0]             rvalid,
   output logic [data_width-1:0]          rdata,
   output logic                           err,
   output logic [addr_width-1:0]          ram_address,
   output logic                           ram_write,
   output logic                           ram_chip_select,
   output logic [data_width-1:0]          ram_data_out,
   output logic                           ram_data_oe,
   input  logic [data_width-1:0]          ram_data_in
);

   localparam int ptr_width = (num_req > 1) ? $clog2(num_req) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

   state_t                  state_q;
   logic [ptr_width-1:0]    ptr_q, ptr_d;
   logic [ptr_width-1:0]    winner;
   logic [num_req-1:0]      win_onehot;
   logic [num_req-1:0]      sel_q;
   logic [num_req-1:0]      gnt_q, rvalid_q;
   logic [data_width-1:0]   rdata_q, ram_data_out_q;
   logic [addr_width-1:0]   ram_address_q;
   logic                    err_q, ram_write_q, ram_cs_q, ram_oe_q;
   logic                    we_q, oor_q;
   logic                    any_req, found;
   logic [addr_width-1:0]   win_addr;
   logic [data_width-1:0]   win_wdata;
   logic                    win_we, win_oor;

   // First requesting index at or after the pointer, wrapping modulo num_req.
   always_comb begin : pick
      int idx;
      any_req = |req;
      found   = 1'b0;
      winner  = '0;
      idx     = 0;
      for (int k = 0; k < num_req; k++) begin
         idx = (int'(ptr_q) + k) % num_req;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = ptr_width'(idx);
         end
      end
      win_onehot = num_req'(1) << winner;
      win_addr   = addr[int'(winner)*addr_width +: addr_width];
      win_wdata  = wdata[int'(winner)*data_width +: data_width];
      win_we     = we[winner];
      win_oor    = 32'(win_addr) >= ram_depth;
      ptr_d      = (int'(winner) == num_req - 1) ? '0 : winner + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         sel_q          <= '0;
         gnt_q          <= '0;
         rvalid_q       <= '0;
         rdata_q        <= '0;
         err_q          <= 1'b0;
         ram_address_q  <= '0;
         ram_write_q    <= 1'b0;
         ram_cs_q       <= 1'b0;
         ram_data_out_q <= '0;
         ram_oe_q       <= 1'b0;
         we_q           <= 1'b0;
         oor_q          <= 1'b0;
      end else begin
         gnt_q    <= '0;
         rvalid_q <= '0;
         err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  sel_q          <= win_onehot;
                  gnt_q          <= win_onehot;
                  err_q          <= win_oor;
                  ram_address_q  <= win_addr;
                  ram_data_out_q <= win_wdata;
                  ram_cs_q       <= ~win_oor;
                  ram_write_q    <= win_we & ~win_oor;
                  ram_oe_q       <= win_we & ~win_oor;
                  we_q           <= win_we;
                  oor_q          <= win_oor;
                  ptr_q          <= ptr_d;
                  state_q        <= ACCESS;
               end
            end
            ACCESS: begin
               ram_cs_q    <= 1'b0;
               ram_write_q <= 1'b0;
               ram_oe_q    <= 1'b0;
               if (we_q) begin
                  state_q <= TURN;
               end else begin
                  rvalid_q <= sel_q;
                  rdata_q  <= oor_q ? '0 : ram_data_in;
                  state_q  <= IDLE;
               end
            end
            TURN:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt             = gnt_q;
   assign rvalid          = rvalid_q;
   assign rdata           = rdata_q;
   assign err             = err_q;
   assign ram_address     = ram_address_q;
   assign ram_write       = ram_write_q;
   assign ram_chip_select = ram_cs_q;
   assign ram_data_out    = ram_data_out_q;
   assign ram_data_oe     = ram_oe_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed table-driven bench for ram_port_arbiter
// Drives inputs just after each rising edge and samples outputs 1 time unit after the edge.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  gnt, rvalid;
   logic [7:0]  rdata;
   logic        err;
   logic [7:0]  ram_address;
   logic        ram_write, ram_chip_select, ram_data_oe;
   logic [7:0]  ram_data_out, ram_data_in;

   logic [7:0]  mem [0:255];
   logic        bd_we;
   logic [7:0]  bd_addr, bd_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.data_width(8), .ram_depth(200), .num_req(4)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
      .ram_address(ram_address), .ram_write(ram_write),
      .ram_chip_select(ram_chip_select), .ram_data_out(ram_data_out),
      .ram_data_oe(ram_data_oe), .ram_data_in(ram_data_in)
   );

   // Single-port RAM model: asynchronous read, write on the edge when strobed and driven.
   assign ram_data_in = (ram_chip_select && !ram_write) ? mem[ram_address] : 8'h00;
   always @(posedge clk) begin
      if (bd_we)
         mem[bd_addr] <= bd_data;
      else if (ram_chip_select && ram_write && ram_data_oe)
         mem[ram_address] <= ram_data_out;
   end

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  gnt;
      logic [3:0]  rvalid;
      logic [7:0]  rdata;
      logic        err;
      logic        cs;
      logic        wr;
      logic        oe;
      logic [7:0]  ra;
      logic [7:0]  dout;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0; we = '0; addr = '0; wdata = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic int bit_idx(input logic [3:0] v);
      for (int b = 0; b < 4; b++)
         if (v[b]) return b;
      return -1;
   endfunction

   // Runs ncyc cycles with req held and checks the sequence of granted requesters.
   task automatic run_held(input string tag, input logic [3:0] held, input int exp_order [5]);
      int          order [$];
      logic [3:0]  prev_gnt;
      prev_gnt = '0;
      req  = held;
      we   = '0;
      addr = 32'h1020_1020;
      for (int c = 0; c < 10; c++) begin
         step();
         check($sformatf("%s gnt_onehot c%0d", tag, c), 32'($countones(gnt) <= 1), 32'd1);
         check($sformatf("%s rvalid_onehot c%0d", tag, c), 32'($countones(rvalid) <= 1), 32'd1);
         if (gnt != 0) begin
            check($sformatf("%s gnt_single_cycle c%0d", tag, c), 32'(prev_gnt), 32'd0);
            order.push_back(bit_idx(gnt));
         end
         prev_gnt = gnt;
      end
      req = '0;
      check($sformatf("%s grant_count", tag), 32'(order.size()), 32'd5);
      for (int g = 0; g < 5 && g < order.size(); g++)
         check($sformatf("%s grant%0d", tag, g), 32'(order[g]), 32'(exp_order[g]));
   endtask

   initial begin
      vecs[0]  = '{4'b0001, 4'b0000, 32'h0000_0010, 32'h0,         4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00};
      vecs[1]  = '{4'b0000, 4'b0000, 32'h0,         32'h0,         4'b0000, 4'b0001, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[2]  = '{4'b0000, 4'b0000, 32'h0,         32'h0,         4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[3]  = '{4'b0010, 4'b0010, 32'h0000_2000, 32'h0000_3C00, 4'b0010, 4'b0000, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 8'h3C};
      vecs[4]  = '{4'b0010, 4'b0000, 32'h0000_2000, 32'h0,         4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[5]  = '{4'b0010, 4'b0000, 32'h0000_2000, 32'h0,         4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[6]  = '{4'b0010, 4'b0000, 32'h0000_2000, 32'h0,         4'b0010, 4'b0000, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00};
      vecs[7]  = '{4'b0000, 4'b0000, 32'h0,         32'h0,         4'b0000, 4'b0010, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[8]  = '{4'b0001, 4'b0000, 32'h0000_00FA, 32'h0,         4'b0001, 4'b0000, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[9]  = '{4'b0000, 4'b0000, 32'h0,         32'h0,         4'b0000, 4'b0001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[10] = '{4'b0100, 4'b0000, 32'h0010_0000, 32'h0,         4'b0100, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00};
      vecs[11] = '{4'b0000, 4'b0000, 32'h0,         32'h0,         4'b0000, 4'b0100, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

      bd_we = 1'b1; bd_addr = 8'h10; bd_data = 8'hA5;
      do_reset();
      bd_we = 1'b0;

      check("reset gnt",     32'(gnt), 32'h0);
      check("reset rvalid",  32'(rvalid), 32'h0);
      check("reset rdata",   32'(rdata), 32'h0);
      check("reset err",     32'(err), 32'h0);
      check("reset cs",      32'(ram_chip_select), 32'h0);
      check("reset write",   32'(ram_write), 32'h0);
      check("reset oe",      32'(ram_data_oe), 32'h0);
      check("reset address", 32'(ram_address), 32'h0);
      check("reset dout",    32'(ram_data_out), 32'h0);

      for (int i = 0; i < 12; i++) begin
         req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
         step();
         check($sformatf("row%0d gnt", i),    32'(gnt),             32'(vecs[i].gnt));
         check($sformatf("row%0d rvalid", i), 32'(rvalid),          32'(vecs[i].rvalid));
         check($sformatf("row%0d rdata", i),  32'(rdata),           32'(vecs[i].rdata));
         check($sformatf("row%0d err", i),    32'(err),             32'(vecs[i].err));
         check($sformatf("row%0d cs", i),     32'(ram_chip_select), 32'(vecs[i].cs));
         check($sformatf("row%0d write", i),  32'(ram_write),       32'(vecs[i].wr));
         check($sformatf("row%0d oe", i),     32'(ram_data_oe),     32'(vecs[i].oe));
         if (vecs[i].cs)
            check($sformatf("row%0d address", i), 32'(ram_address), 32'(vecs[i].ra));
         if (vecs[i].wr)
            check($sformatf("row%0d dout", i),    32'(ram_data_out), 32'(vecs[i].dout));
      end

      do_reset();
      run_held("contention", 4'b1111, '{0, 1, 2, 3, 0});

      do_reset();
      run_held("fairness", 4'b0101, '{0, 2, 0, 2, 0});

      // Abort a read in ACCESS, then req3 and req0 pending: pointer reset means req0 first.
      do_reset();
      req = 4'b0010; we = '0; addr = 32'h0000_2000;
      step();
      check("abort gnt_before", 32'(gnt), 32'h2);
      rst = 1'b1;
      req = 4'b1001; addr = 32'h1000_0020;
      step();
      check("abort gnt",    32'(gnt), 32'h0);
      check("abort rvalid", 32'(rvalid), 32'h0);
      check("abort cs",     32'(ram_chip_select), 32'h0);
      check("abort rdata",  32'(rdata), 32'h0);
      rst = 1'b0;
      step();
      check("abort next gnt",    32'(gnt), 32'h1);
      check("abort next rvalid", 32'(rvalid), 32'h0);
      req = 4'b1000;
      step();
      check("abort rd0 rvalid", 32'(rvalid), 32'h1);
      check("abort rd0 rdata",  32'(rdata), 32'h3C);
      step();
      check("abort gnt3", 32'(gnt), 32'h8);
      req = 4'b0000;
      step();
      check("abort rd3 rvalid", 32'(rvalid), 32'h8);
      check("abort rd3 rdata",  32'(rdata), 32'hA5);
      step();
      check("final idle gnt", 32'(gnt), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
